reorder_buffer: RTL and testbench

//  2-wide in-order-allocate / out-of-order-complete / in-order-retire reorder buffer, directly downstream of rename.

---
 rtl/rob_pkg.sv | 17 +
 rtl/reorder_buffer.sv | 131 +++++++++++++
 tb/tb_reorder_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared widths and the entry layout for the reorder buffer.
package rob_pkg;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned ARCH_W    = 5;
    localparam int unsigned PHYS_W    = 6;

    // One in-flight instruction: rename results plus completion status.
    typedef struct packed {
        logic              valid;
        logic              done;
        logic [ARCH_W-1:0] rd_arch;
        logic [PHYS_W-1:0] rd_phys;
        logic [PHYS_W-1:0] old_phys;
    } rob_entry_t;

endpackage : rob_pkg

// File: rtl/reorder_buffer.sv
// 2-wide reorder buffer: in-order allocate, out-of-order complete, in-order retire.
// Retiring entries hand their previous phys mapping back to the free pool.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       alloc_valid_a,
    input  logic [ARCH_W-1:0]          alloc_rd_arch_a,
    input  logic [PHYS_W-1:0]          alloc_rd_phys_a,
    input  logic [PHYS_W-1:0]          alloc_old_phys_a,
    input  logic                       alloc_valid_b,
    input  logic [ARCH_W-1:0]          alloc_rd_arch_b,
    input  logic [PHYS_W-1:0]          alloc_rd_phys_b,
    input  logic [PHYS_W-1:0]          alloc_old_phys_b,
    output logic                       alloc_ready,
    output logic [$clog2(DEPTH)-1:0]   rob_idx_a,
    output logic [$clog2(DEPTH)-1:0]   rob_idx_b,

    input  logic                       wb_valid_0,
    input  logic [$clog2(DEPTH)-1:0]   wb_idx_0,
    input  logic                       wb_valid_1,
    input  logic [$clog2(DEPTH)-1:0]   wb_idx_1,

    output logic                       retire_valid_a,
    output logic [ARCH_W-1:0]          retire_rd_arch_a,
    output logic [PHYS_W-1:0]          retire_rd_phys_a,
    output logic [PHYS_W-1:0]          retire_old_phys_a,
    output logic                       retire_valid_b,
    output logic [ARCH_W-1:0]          retire_rd_arch_b,
    output logic [PHYS_W-1:0]          retire_rd_phys_b,
    output logic [PHYS_W-1:0]          retire_old_phys_b,

    output logic [$clog2(DEPTH):0]     rob_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    // Two free slots are needed before a dual allocation is allowed.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    rob_entry_t       rob_q [DEPTH];
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [IDX_W-1:0] head_p1;
    logic [IDX_W-1:0] tail_p1;
    logic             acc_a;
    logic             acc_b;
    logic [1:0]       n_alloc;
    logic [1:0]       n_retire;
    rob_entry_t       head_entry;
    rob_entry_t       next_entry;

    // Pointer arithmetic, allocation accept and retire selection from current state.
    always_comb begin
        head_p1    = head_q + IDX_W'(1);
        tail_p1    = tail_q + IDX_W'(1);
        head_entry = rob_q[head_q];
        next_entry = rob_q[head_p1];

        alloc_ready = (count_q <= READY_MAX);
        acc_a       = alloc_ready & alloc_valid_a;
        acc_b       = acc_a & alloc_valid_b;
        n_alloc     = {1'b0, acc_a} + {1'b0, acc_b};

        retire_valid_a = head_entry.valid & head_entry.done;
        retire_valid_b = retire_valid_a & next_entry.valid & next_entry.done;
        n_retire       = {1'b0, retire_valid_a} + {1'b0, retire_valid_b};
    end

    assign rob_idx_a         = tail_q;
    assign rob_idx_b         = tail_p1;
    assign rob_count         = count_q;
    assign retire_rd_arch_a  = head_entry.rd_arch;
    assign retire_rd_phys_a  = head_entry.rd_phys;
    assign retire_old_phys_a = head_entry.old_phys;
    assign retire_rd_arch_b  = next_entry.rd_arch;
    assign retire_rd_phys_b  = next_entry.rd_phys;
    assign retire_old_phys_b = next_entry.old_phys;

    // Entry array and pointers: writeback, then retire clear, then allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            rob_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Completion only lands on live entries; a stale index is dropped.
            if (wb_valid_0 && rob_q[wb_idx_0].valid) begin
                rob_q[wb_idx_0].done <= 1'b1;
            end
            if (wb_valid_1 && rob_q[wb_idx_1].valid) begin
                rob_q[wb_idx_1].done <= 1'b1;
            end

            if (retire_valid_a) begin
                rob_q[head_q] <= '0;
            end
            if (retire_valid_b) begin
                rob_q[head_p1] <= '0;
            end

            // Allocation slots are free whenever alloc_ready, so they never collide with retire.
            if (acc_a) begin
                rob_q[tail_q] <= '{valid:    1'b1,
                                   done:     1'b0,
                                   rd_arch:  alloc_rd_arch_a,
                                   rd_phys:  alloc_rd_phys_a,
                                   old_phys: alloc_old_phys_a};
            end
            if (acc_b) begin
                rob_q[tail_p1] <= '{valid:    1'b1,
                                    done:     1'b0,
                                    rd_arch:  alloc_rd_arch_b,
                                    rd_phys:  alloc_rd_phys_b,
                                    old_phys: alloc_old_phys_b};
            end

            head_q  <= head_q + IDX_W'(n_retire);
            tail_q  <= tail_q + IDX_W'(n_alloc);
            count_q <= count_q + CNT_W'(n_alloc) - CNT_W'(n_retire);
        end
    end

endmodule : reorder_buffer

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order retire scoreboard.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic              clk;
    logic              reset;
    logic              alloc_valid_a, alloc_valid_b;
    logic [ARCH_W-1:0] alloc_rd_arch_a, alloc_rd_arch_b;
    logic [PHYS_W-1:0] alloc_rd_phys_a, alloc_rd_phys_b;
    logic [PHYS_W-1:0] alloc_old_phys_a, alloc_old_phys_b;
    logic              alloc_ready;
    logic [3:0]        rob_idx_a, rob_idx_b;
    logic              wb_valid_0, wb_valid_1;
    logic [3:0]        wb_idx_0, wb_idx_1;
    logic              retire_valid_a, retire_valid_b;
    logic [ARCH_W-1:0] retire_rd_arch_a, retire_rd_arch_b;
    logic [PHYS_W-1:0] retire_rd_phys_a, retire_rd_phys_b;
    logic [PHYS_W-1:0] retire_old_phys_a, retire_old_phys_b;
    logic [4:0]        rob_count;

    int checks = 0;
    int errors = 0;
    int seq    = 0;
    logic [16:0] exp_q [$];

    reorder_buffer #(.DEPTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .alloc_valid_a     (alloc_valid_a),
        .alloc_rd_arch_a   (alloc_rd_arch_a),
        .alloc_rd_phys_a   (alloc_rd_phys_a),
        .alloc_old_phys_a  (alloc_old_phys_a),
        .alloc_valid_b     (alloc_valid_b),
        .alloc_rd_arch_b   (alloc_rd_arch_b),
        .alloc_rd_phys_b   (alloc_rd_phys_b),
        .alloc_old_phys_b  (alloc_old_phys_b),
        .alloc_ready       (alloc_ready),
        .rob_idx_a         (rob_idx_a),
        .rob_idx_b         (rob_idx_b),
        .wb_valid_0        (wb_valid_0),
        .wb_idx_0          (wb_idx_0),
        .wb_valid_1        (wb_valid_1),
        .wb_idx_1          (wb_idx_1),
        .retire_valid_a    (retire_valid_a),
        .retire_rd_arch_a  (retire_rd_arch_a),
        .retire_rd_phys_a  (retire_rd_phys_a),
        .retire_old_phys_a (retire_old_phys_a),
        .retire_valid_b    (retire_valid_b),
        .retire_rd_arch_b  (retire_rd_arch_b),
        .retire_rd_phys_b  (retire_rd_phys_b),
        .retire_old_phys_b (retire_old_phys_b),
        .rob_count         (rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        alloc_valid_a = 1'b0; alloc_valid_b = 1'b0;
        alloc_rd_arch_a = '0; alloc_rd_phys_a = '0; alloc_old_phys_a = '0;
        alloc_rd_arch_b = '0; alloc_rd_phys_b = '0; alloc_old_phys_b = '0;
        wb_valid_0 = 1'b0; wb_valid_1 = 1'b0; wb_idx_0 = '0; wb_idx_1 = '0;
    endtask

    task automatic set_alloc(input logic [4:0] ra, input logic [5:0] pa, input logic [5:0] oa,
                             input logic [4:0] rb, input logic [5:0] pb, input logic [5:0] ob,
                             input bit push);
        alloc_valid_a = 1'b1; alloc_rd_arch_a = ra; alloc_rd_phys_a = pa; alloc_old_phys_a = oa;
        alloc_valid_b = 1'b1; alloc_rd_arch_b = rb; alloc_rd_phys_b = pb; alloc_old_phys_b = ob;
        if (push) begin
            exp_q.push_back({ra, pa, oa});
            exp_q.push_back({rb, pb, ob});
        end
    endtask

    // Dual allocation with unique generated fields.
    task automatic alloc_seq(input bit push);
        set_alloc(5'(seq), 6'(seq), 6'(seq + 17), 5'(seq + 1), 6'(seq + 1), 6'(seq + 18), push);
        seq += 2;
    endtask

    task automatic set_wb(input logic [3:0] i0, input logic [3:0] i1);
        wb_valid_0 = 1'b1; wb_idx_0 = i0;
        wb_valid_1 = 1'b1; wb_idx_1 = i1;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic drain(input string tag);
        idle();
        for (int n = 0; n < 40 && rob_count != 0; n++) cycle();
        check({tag, "_count"}, 32'(rob_count), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Every retire must match the oldest outstanding allocation.
    always @(negedge clk) begin
        if (!reset && retire_valid_a) begin
            if (exp_q.size() == 0) check("ret_a_unexpected", 32'd1, 32'd0);
            else check("ret_a_order", 32'({retire_rd_arch_a, retire_rd_phys_a, retire_old_phys_a}),
                       32'(exp_q.pop_front()));
        end
        if (!reset && retire_valid_b) begin
            if (exp_q.size() == 0) check("ret_b_unexpected", 32'd1, 32'd0);
            else check("ret_b_order", 32'({retire_rd_arch_b, retire_rd_phys_b, retire_old_phys_b}),
                       32'(exp_q.pop_front()));
        end
    end

    // Slot b must never be offered without slot a.
    always @(posedge clk) begin
        if (!reset) assert (!(alloc_valid_b && !alloc_valid_a)) else $error("FAIL alloc_b_without_a");
    end

    initial begin
        logic [3:0] m_tail;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_count", 32'(rob_count), 32'd0);
        check("rst_rv_a", 32'(retire_valid_a), 32'd0);
        check("rst_rv_b", 32'(retire_valid_b), 32'd0);
        check("rst_idx_a", 32'(rob_idx_a), 32'd0);
        check("rst_idx_b", 32'(rob_idx_b), 32'd1);

        // Basic dual alloc, dual writeback, dual retire
        set_alloc(5'd3, 6'd33, 6'd3, 5'd5, 6'd34, 6'd5, 1'b1);
        cycle();
        check("t1_count2", 32'(rob_count), 32'd2);
        check("t1_no_ret", 32'(retire_valid_a), 32'd0);
        set_wb(4'd0, 4'd1);
        cycle();
        check("t1_rv_a", 32'(retire_valid_a), 32'd1);
        check("t1_rv_b", 32'(retire_valid_b), 32'd1);
        check("t1_old_a", 32'(retire_old_phys_a), 32'd3);
        check("t1_old_b", 32'(retire_old_phys_b), 32'd5);
        check("t1_phys_b", 32'(retire_rd_phys_b), 32'd34);
        cycle();
        check("t1_count0", 32'(rob_count), 32'd0);
        check("t1_idx_a", 32'(rob_idx_a), 32'd2);

        // Out-of-order completion holds retire until the head completes
        set_alloc(5'd1, 6'd40, 6'd1, 5'd2, 6'd41, 6'd2, 1'b1);
        cycle();
        set_wb(4'd3, 4'd3);
        cycle();
        check("t2_hold_a", 32'(retire_valid_a), 32'd0);
        check("t2_hold_b", 32'(retire_valid_b), 32'd0);
        check("t2_count", 32'(rob_count), 32'd2);
        set_wb(4'd2, 4'd2);
        cycle();
        check("t2_rv_a", 32'(retire_valid_a), 32'd1);
        check("t2_rv_b", 32'(retire_valid_b), 32'd1);
        check("t2_old_b", 32'(retire_old_phys_b), 32'd2);
        drain("t2");

        // Fill to DEPTH starting from index 4
        for (int k = 0; k < 8; k++) begin
            check("t3_ready", 32'(alloc_ready), 32'd1);
            alloc_seq(1'b1);
            cycle();
        end
        check("t3_full_count", 32'(rob_count), 32'd16);
        check("t3_full_ready", 32'(alloc_ready), 32'd0);
        check("t3_full_idx", 32'(rob_idx_a), 32'd4);
        alloc_seq(1'b0);
        cycle();
        check("t3_rej_count", 32'(rob_count), 32'd16);
        check("t3_rej_idx", 32'(rob_idx_a), 32'd4);
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                check("t3_full_retire", 32'(retire_valid_b), 32'd1);
                check("t3_full_cnt_ret", 32'(rob_count), 32'd16);
            end
            set_wb(4'(4 + 2 * k), 4'(5 + 2 * k));
            cycle();
        end
        drain("t3");

        // Steady-state 2 alloc / 2 retire across the wrap point
        m_tail = 4'd4;
        for (int k = 0; k < 40; k++) begin
            check("t4_idx", 32'(rob_idx_a), 32'(m_tail));
            if (k >= 2) check("t4_count", 32'(rob_count), 32'd4);
            alloc_seq(1'b1);
            if (k >= 1) set_wb(m_tail - 4'd2, m_tail - 4'd1);
            cycle();
            m_tail = m_tail + 4'd2;
        end
        set_wb(m_tail - 4'd2, m_tail - 4'd1);
        cycle();
        drain("t4");

        // Reset with 10 entries pending, plus a stale writeback afterwards
        for (int k = 0; k < 5; k++) begin
            alloc_seq(1'b1);
            cycle();
        end
        check("t5_pending", 32'(rob_count), 32'd10);
        m_tail = rob_idx_a;
        reset = 1'b1;
        set_wb(m_tail - 4'd10, m_tail - 4'd9);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle();
        exp_q.delete();
        check("t5_count", 32'(rob_count), 32'd0);
        check("t5_rv_a", 32'(retire_valid_a), 32'd0);
        check("t5_rv_b", 32'(retire_valid_b), 32'd0);
        check("t5_idx", 32'(rob_idx_a), 32'd0);
        set_wb(4'd0, 4'd1);
        cycle();
        alloc_seq(1'b1);
        cycle();
        check("t5_stale_a", 32'(retire_valid_a), 32'd0);
        cycle();
        check("t5_stale_a2", 32'(retire_valid_a), 32'd0);
        check("t5_count2", 32'(rob_count), 32'd2);
        set_wb(4'd0, 4'd1);
        cycle();
        check("t5_rv_after", 32'(retire_valid_b), 32'd1);
        drain("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reorder_buffer
